fetch_unit: RTL
===============

Name: fetch_unit

Overview:
Instruction fetch stage, directly upstream of decode. Keeps the PC and issues word requests to instruction memory over a valid/ready request channel. Buffers returned instructions with their PCs in a small FIFO and presents one instruction per cycle to decode as f_pc/inst. Supports decode-side stall and execute-side redirect (taken branch/jump), and discards stale in-flight responses.

Parameters:
RESET_PC, 32'h0100_0000, PC fetched first after reset release
FIFO_DEPTH, 2, instruction buffer entries (power of two, >=2)

Ports:
clock  in  1  system clock, all state on rising edge
reset_n  in  1  asynchronous active-low reset
imem_req_valid  out  1  fetch request valid (combinational from state)
imem_req_ready  in  1  memory accepts request this cycle
imem_req_addr  out  32  word address of request, bits[1:0]=0
imem_resp_valid  in  1  response data valid (>=1 cycle after acceptance)
imem_resp_data  in  32  instruction word
redirect_valid  in  1  execute requests PC change
redirect_pc  in  32  new fetch PC
stall  in  1  decode cannot accept this cycle
f_valid  out  1  f_pc/inst hold a real instruction
f_pc  out  32  PC of presented instruction
inst  out  32  presented instruction; NOP when f_valid=0

Behaviour:
- Reset (async assert, sync-safe release): pc=RESET_PC, FIFO empty, outstanding=0, epoch=0; imem_req_valid=0, f_valid=0, f_pc=0, inst=32'h0000_0013 (NOP).
- State: pc, outstanding (0/1, at most one request in flight), epoch bit, req_epoch (epoch at issue), req_pc, FIFO of {pc, inst}, count.
- pop = f_valid && !stall. Head entry leaves FIFO at edge.
- can_issue = (!outstanding || imem_resp_valid) && (count + outstanding - pop - resp_accepted_into_fifo ... ) evaluated as: entries_after = count - pop + (outstanding ? 1 : 0); issue allowed when entries_after < FIFO_DEPTH.
- imem_req_valid = can_issue && !redirect_valid && reset released. imem_req_addr = pc. Request may be withdrawn (no stability rule). On valid&&ready: outstanding<=1, req_pc<=pc, req_epoch<=epoch, pc<=pc+4 (32-bit wrap 0xFFFF_FFFC -> 0).
- Response: imem_resp_valid with outstanding=1 clears outstanding (unless new request accepted same cycle). If req_epoch==epoch, push {req_pc, imem_resp_data}; else drop silently. imem_resp_valid with outstanding=0 is ignored.
- Space is guaranteed by the issue rule; push into full FIFO cannot occur (assertion in bench).
- Latency: response in cycle N is visible on f_* in cycle N+1 (registered storage, head read combinationally). With 1-cycle memory and no stall, sustained 1 instruction/cycle; first instruction after reset at cycle 3.
- Outputs: f_valid = count!=0; f_pc/inst = head; when empty f_pc holds last presented value, inst=NOP.
- Stall: head held stable; fetching continues until FIFO plus outstanding reaches FIFO_DEPTH.
- Redirect (highest priority): FIFO flushed (count=0), pc<=redirect_pc & ~3, no request issued that cycle; if outstanding, epoch toggles so its response is dropped. Response arriving in redirect cycle is dropped. Redirect during stall still flushes. Simultaneous pop and redirect: flush wins, f_valid=0 next cycle.
- Back-to-back redirects: each toggles epoch only if a request is outstanding; pc takes latest.
- Reset mid-operation: all state returns to reset values immediately; later memory responses ignored (outstanding=0).

Decomposition:
- riscv_pkg: NOP_INST=32'h0000_0013, DEFAULT_RESET_PC, XLEN=32, opcode constants shared with decode.
- Sub-module fetch_fifo: parameterised {pc,inst} FIFO with push/pop/flush, count, head outputs, async active-low reset.

Test Plan:
- Reset release, 1-cycle memory returning 32'h00A00093 at 0x01000000 -> addr 0x01000000 cycle 1, f_valid=1, f_pc=0x01000000, inst=0x00A00093 cycle 3; then PCs +4 every cycle.
- stall held 5 cycles with FIFO_DEPTH=2 -> exactly 2 buffered, imem_req_valid=0 afterwards, head unchanged; release -> entries in order, no loss/duplicate.
- Redirect to 0x01000103 while request outstanding -> old response dropped, next req addr 0x01000100, f_valid=0 until new response.
- Redirect same cycle as response and pop -> response dropped, FIFO empty next cycle, inst=NOP.
- 3-cycle memory latency -> one request in flight, f_valid pulses every 3 cycles, PCs contiguous.
- pc=0xFFFFFFFC fetched -> next req addr 0x00000000; reset_n asserted mid-fetch -> outputs reset asynchronously, late response ignored.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32 definitions: core widths, NOP encoding,
// opcode map and the fetch->decode entry bundle.
package riscv_pkg;

  localparam int XLEN = 32;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0100_0000;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     inst;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] word_align(
    input logic [XLEN-1:0] a
  );
    return {a[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small {pc,inst} buffer between fetch and decode.
// Flush beats push/pop; head is read combinationally.
module fetch_fifo
  import riscv_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  fetch_entry_t           din,
  output fetch_entry_t           head,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  fetch_entry_t mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;

  assign head = mem[rd_ptr];

  // pointer and occupancy tracking
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // payload storage; contents are don't-care until counted
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC, single in-flight imem request,
// epoch-tagged responses, buffered hand-off to decode.
module fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clock,
  input  logic        reset_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic        f_valid,
  output logic [31:0] f_pc,
  output logic [31:0] inst
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [31:0]   pc;
  logic          outstanding;
  logic          epoch;
  logic          req_epoch;
  logic [31:0]   req_pc;
  logic [31:0]   last_pc;

  logic [CW-1:0] fifo_count;
  fetch_entry_t  head;
  fetch_entry_t  din;

  logic          pop;
  logic          push;
  logic          resp_fire;
  logic          req_fire;
  logic          can_issue;
  logic [CW:0]   entries_after;

  assign f_valid = (fifo_count != '0);
  assign f_pc    = f_valid ? head.pc : last_pc;
  assign inst    = f_valid ? head.inst : NOP_INST;

  assign pop       = f_valid && !stall;
  assign resp_fire = imem_resp_valid && outstanding;
  assign push      = resp_fire && (req_epoch == epoch)
                     && !redirect_valid;

  // the in-flight request always owns a slot it may fill
  assign entries_after = {1'b0, fifo_count}
                         - (CW+1)'(pop)
                         + (CW+1)'(outstanding);

  assign can_issue = (!outstanding || imem_resp_valid)
                     && (entries_after < (CW+1)'(FIFO_DEPTH));

  assign imem_req_valid = can_issue && !redirect_valid && reset_n;
  assign imem_req_addr  = pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign din = '{pc: req_pc, inst: imem_resp_data};

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clock),
    .rst_n (reset_n),
    .push  (push),
    .pop   (pop),
    .flush (redirect_valid),
    .din   (din),
    .head  (head),
    .count (fifo_count)
  );

  // PC steering and epoch; a one-bit epoch only stays
  // correct if an already-stale request is not re-tagged,
  // so back-to-back redirects toggle it once
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pc    <= RESET_PC;
      epoch <= 1'b0;
    end else if (redirect_valid) begin
      pc <= word_align(redirect_pc);
      if (outstanding && !imem_resp_valid
          && (req_epoch == epoch))
        epoch <= ~epoch;
    end else if (req_fire) begin
      pc <= pc + 32'd4;
    end
  end

  // in-flight request bookkeeping
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      outstanding <= 1'b0;
      req_epoch   <= 1'b0;
      req_pc      <= '0;
    end else if (req_fire) begin
      outstanding <= 1'b1;
      req_epoch   <= epoch;
      req_pc      <= pc;
    end else if (resp_fire) begin
      outstanding <= 1'b0;
    end
  end

  // remember the last presented pc for the empty case
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      last_pc <= '0;
    end else if (f_valid) begin
      last_pc <= head.pc;
    end
  end

endmodule
